// File: rtl/mor1kx_store_buffer_combining.sv
// Store buffer between the LSU and the data bus: register FIFO with fall-through head,
// write combining into the youngest entry, and a load-address snoop over pending stores.
module mor1kx_store_buffer_combining #(
    parameter int DEPTH_WIDTH          = 2,
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int COMBINE_EN           = 1,
    parameter int ALMOST_FULL_LEVEL    = 3
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [OPTION_OPERAND_WIDTH-1:0]   pc_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]   adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]   dat_i,
    input  logic [OPTION_OPERAND_WIDTH/8-1:0] bsel_i,
    input  logic                              atomic_i,
    input  logic                              write_i,
    input  logic                              read_i,
    output logic [OPTION_OPERAND_WIDTH-1:0]   pc_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]   adr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]   dat_o,
    output logic [OPTION_OPERAND_WIDTH/8-1:0] bsel_o,
    output logic                              atomic_o,
    input  logic [OPTION_OPERAND_WIDTH-1:0]   snoop_adr_i,
    output logic                              snoop_hit_o,
    output logic                              combined_o,
    output logic [DEPTH_WIDTH:0]              count_o,
    output logic                              full_o,
    output logic                              almost_full_o,
    output logic                              empty_o
);

    localparam int OW       = OPTION_OPERAND_WIDTH;
    localparam int BW       = OW / 8;
    localparam int DEPTH    = 2 ** DEPTH_WIDTH;
    localparam int WORD_LSB = $clog2(BW);
    localparam logic [DEPTH_WIDTH:0]   PTR_ONE = (DEPTH_WIDTH+1)'(1);
    localparam logic [DEPTH_WIDTH-1:0] IDX_ONE = DEPTH_WIDTH'(1);

    logic [OW-1:0] pc_q   [DEPTH];
    logic [OW-1:0] adr_q  [DEPTH];
    logic [OW-1:0] dat_q  [DEPTH];
    logic [BW-1:0] bsel_q [DEPTH];
    logic          atomic_q [DEPTH];

    logic [DEPTH_WIDTH:0]   wptr;
    logic [DEPTH_WIDTH:0]   rptr;
    logic [DEPTH_WIDTH-1:0] widx;
    logic [DEPTH_WIDTH-1:0] ridx;
    logic [DEPTH_WIDTH-1:0] last_idx;
    logic                   combine;
    logic                   push;
    logic                   pop;

    assign widx     = wptr[DEPTH_WIDTH-1:0];
    assign ridx     = rptr[DEPTH_WIDTH-1:0];
    assign last_idx = widx - IDX_ONE;

    assign count_o       = wptr - rptr;
    assign empty_o       = (wptr == rptr);
    assign full_o        = (wptr[DEPTH_WIDTH] != rptr[DEPTH_WIDTH]) && (widx == ridx);
    assign almost_full_o = (count_o >= (DEPTH_WIDTH+1)'(ALMOST_FULL_LEVEL));

    assign pc_o     = pc_q[ridx];
    assign adr_o    = adr_q[ridx];
    assign dat_o    = dat_q[ridx];
    assign bsel_o   = bsel_q[ridx];
    assign atomic_o = atomic_q[ridx];

    // Merging into an entry that is leaving this cycle would lose the new bytes.
    assign combine = (COMBINE_EN != 0) && write_i && !empty_o && !atomic_i &&
                     !atomic_q[last_idx] &&
                     (adr_i[OW-1:WORD_LSB] == adr_q[last_idx][OW-1:WORD_LSB]) &&
                     !(read_i && (count_o == PTR_ONE));
    assign combined_o = combine;
    assign push       = write_i && !combine && (!full_o || read_i);
    assign pop        = read_i && !empty_o;

    always_comb begin
        logic [DEPTH_WIDTH-1:0] offset;
        offset      = '0;
        snoop_hit_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = DEPTH_WIDTH'(i) - ridx;
            if (({1'b0, offset} < count_o) &&
                (adr_q[i][OW-1:WORD_LSB] == snoop_adr_i[OW-1:WORD_LSB]))
                snoop_hit_o = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]     <= '0;
                adr_q[i]    <= '0;
                dat_q[i]    <= '0;
                bsel_q[i]   <= '0;
                atomic_q[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                pc_q[widx]     <= pc_i;
                adr_q[widx]    <= adr_i;
                dat_q[widx]    <= dat_i;
                bsel_q[widx]   <= bsel_i;
                atomic_q[widx] <= atomic_i;
                wptr           <= wptr + PTR_ONE;
            end
            if (combine) begin
                pc_q[last_idx]   <= pc_i;
                adr_q[last_idx]  <= adr_i;
                bsel_q[last_idx] <= bsel_q[last_idx] | bsel_i;
                for (int b = 0; b < BW; b++)
                    if (bsel_i[b])
                        dat_q[last_idx][8*b +: 8] <= dat_i[8*b +: 8];
            end
            if (pop)
                rptr <= rptr + PTR_ONE;
        end
    end

`ifndef SYNTHESIS
    // A write that is neither merged nor accepted is an LSU protocol violation.
    no_write_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(write_i && full_o && !read_i && !combine))
        else $error("store buffer write dropped while full");
`endif

endmodule
